// File: rtl/seq_match_fsm.sv
// Level-sequence detector: walks a LEN-step pattern on input A, with per-step hold
// qualification, optional per-step timeout, a sticky completion flag and a saturating match count.
module seq_match_fsm #(
    parameter int unsigned LEN     = 4,
    parameter int unsigned HOLD    = 1,
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    En,
    input  logic                    A,
    input  logic [LEN-1:0]          Pattern,
    output logic                    F,
    output logic                    G,
    output logic                    Err,
    output logic [$clog2(LEN)-1:0]  Step,
    output logic [CNT_W-1:0]        Count
);

    localparam int unsigned StepW     = $clog2(LEN);
    localparam int unsigned HoldW     = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int unsigned TmoW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TmoLastI  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [StepW-1:0] LastStep = StepW'(LEN - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TmoLastI);

    typedef enum logic [2:0] {
        ActWait,
        ActAdvance,
        ActTimeout,
        ActAbort,
        ActIllegal
    } action_e;

    logic [StepW-1:0] step_q, step_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic [LEN-1:0]   pat_q, pat_d;
    logic             f_q, f_d;
    logic             g_q, g_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             capture;
    logic [LEN-1:0]   pat_eff;
    logic             match;
    logic             advance;
    logic             timeout;
    logic             illegal;
    logic [StepW-1:0] step_inc;
    action_e          action;

    // Only reachable when LEN is not a power of two.
    if ((2 ** StepW) > LEN) begin : g_illegal
        assign illegal = (step_q > LastStep);
    end else begin : g_no_illegal
        assign illegal = 1'b0;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            step_q <= '0;
            hold_q <= '0;
            tmo_q  <= '0;
            pat_q  <= Pattern;
            f_q    <= 1'b0;
            g_q    <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            step_q <= step_d;
            hold_q <= hold_d;
            tmo_q  <= tmo_d;
            pat_q  <= pat_d;
            f_q    <= f_d;
            g_q    <= g_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        step_d = step_q;
        hold_d = hold_q;
        tmo_d  = tmo_q;
        pat_d  = pat_q;
        f_d    = f_q;
        g_d    = g_q;
        err_d  = 1'b0;
        cnt_d  = cnt_q;

        // The live Pattern is used on the capture cycle so step 0 sees the value being latched.
        capture  = (step_q == '0) && (hold_q == '0);
        pat_eff  = capture ? Pattern : pat_q;
        if (capture) begin
            pat_d = Pattern;
        end
        match    = (A == pat_eff[step_q]);
        advance  = match && (hold_q == HoldLast);
        timeout  = (TIMEOUT != 0) && (step_q != '0) && (tmo_q == TmoLast);
        step_inc = step_q + 1'b1;

        if (!En) begin
            action = ActAbort;
        end else if (illegal) begin
            action = ActIllegal;
        end else if (advance) begin
            action = ActAdvance;
        end else if (timeout) begin
            action = ActTimeout;
        end else begin
            action = ActWait;
        end

        unique case (action)
            ActAbort, ActIllegal: begin
                step_d = '0;
                hold_d = '0;
                tmo_d  = '0;
                f_d    = 1'b0;
            end
            ActAdvance: begin
                hold_d = '0;
                tmo_d  = '0;
                if (step_q == LastStep) begin
                    step_d = '0;
                    f_d    = 1'b0;
                    g_d    = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    step_d = step_inc;
                    f_d    = (step_inc == LastStep);
                    if (step_q == '0) begin
                        g_d = 1'b0;
                    end
                end
            end
            ActTimeout: begin
                step_d = '0;
                hold_d = '0;
                tmo_d  = '0;
                f_d    = 1'b0;
                err_d  = 1'b1;
            end
            default: begin
                hold_d = match ? hold_q + 1'b1 : '0;
                if ((TIMEOUT != 0) && (step_q != '0)) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase
    end

    assign Step  = step_q;
    assign F     = f_q;
    assign G     = g_q;
    assign Err   = err_q;
    assign Count = cnt_q;

endmodule

// File: tb/tb_seq_match_fsm.sv
// Bench for seq_match_fsm: two parameterisations driven in parallel, directed scenarios
// followed by biased random traffic, all checked against a step-rule reference model.
module tb_seq_match_fsm;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic       Reset, En, A;
    logic [3:0] Pattern;

    logic       fa, ga, ea;
    logic [1:0] sa;
    logic [1:0] ca;
    logic       fb, gb, eb;
    logic [1:0] sb;
    logic [7:0] cb;

    seq_match_fsm #(.LEN(4), .HOLD(1), .TIMEOUT(5), .CNT_W(2)) dut_a (
        .Clock(Clock), .Reset(Reset), .En(En), .A(A), .Pattern(Pattern),
        .F(fa), .G(ga), .Err(ea), .Step(sa), .Count(ca)
    );

    seq_match_fsm #(.LEN(4), .HOLD(3), .TIMEOUT(0), .CNT_W(8)) dut_b (
        .Clock(Clock), .Reset(Reset), .En(En), .A(A), .Pattern(Pattern),
        .F(fb), .G(gb), .Err(eb), .Step(sb), .Count(cb)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state, one slot per DUT.
    int         m_step[2];
    int         m_hold[2];
    int         m_tmo[2];
    int         m_cnt[2];
    bit         m_g[2];
    bit         m_err[2];
    logic [3:0] m_pat[2];
    int         hp[2]   = '{1, 3};
    int         tp[2]   = '{5, 0};
    int         cmax[2] = '{3, 255};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input int i, input logic r, input logic en, input logic a,
                                input logic [3:0] p);
        logic [3:0] eff;
        logic       match, adv;
        if (r) begin
            m_step[i] = 0; m_hold[i] = 0; m_tmo[i] = 0; m_pat[i] = p;
            m_g[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
            return;
        end
        eff = (m_step[i] == 0 && m_hold[i] == 0) ? p : m_pat[i];
        m_pat[i] = eff;
        m_err[i] = 0;
        if (!en) begin
            m_step[i] = 0; m_hold[i] = 0; m_tmo[i] = 0;
            return;
        end
        match = (a == eff[m_step[i]]);
        adv   = match && (m_hold[i] == hp[i] - 1);
        if (adv) begin
            m_hold[i] = 0;
            m_tmo[i]  = 0;
            if (m_step[i] == 0) m_g[i] = 0;
            if (m_step[i] == 3) begin
                m_step[i] = 0;
                m_g[i]    = 1;
                if (m_cnt[i] < cmax[i]) m_cnt[i]++;
            end else begin
                m_step[i]++;
            end
        end else if (tp[i] != 0 && m_step[i] != 0 && m_tmo[i] == tp[i] - 1) begin
            m_step[i] = 0; m_hold[i] = 0; m_tmo[i] = 0; m_err[i] = 1;
        end else begin
            m_hold[i] = match ? m_hold[i] + 1 : 0;
            if (tp[i] != 0 && m_step[i] != 0) m_tmo[i]++;
        end
    endtask

    task automatic check_model();
        check("a.step",  32'(sa), 32'(m_step[0]));
        check("a.f",     32'(fa), 32'(m_step[0] == 3));
        check("a.g",     32'(ga), 32'(m_g[0]));
        check("a.err",   32'(ea), 32'(m_err[0]));
        check("a.count", 32'(ca), 32'(m_cnt[0]));
        check("b.step",  32'(sb), 32'(m_step[1]));
        check("b.f",     32'(fb), 32'(m_step[1] == 3));
        check("b.g",     32'(gb), 32'(m_g[1]));
        check("b.err",   32'(eb), 32'(m_err[1]));
        check("b.count", 32'(cb), 32'(m_cnt[1]));
    endtask

    task automatic cycle(input logic r, input logic en, input logic a, input logic [3:0] p);
        Reset = r; En = en; A = a; Pattern = p;
        @(posedge Clock);
        model_update(0, r, en, a, p);
        model_update(1, r, en, a, p);
        #1;
        check_model();
    endtask

    task automatic run_seq(input logic [3:0] p);
        cycle(1'b0, 1'b1, 1'b1, p);
        cycle(1'b0, 1'b1, 1'b0, p);
        cycle(1'b0, 1'b1, 1'b1, p);
        cycle(1'b0, 1'b1, 1'b0, p);
    endtask

    localparam logic [3:0] P0 = 4'b0101;
    localparam logic [3:0] P1 = 4'b1010;

    initial begin
        logic [3:0] pat;
        logic [3:0] eff;
        logic       r, en, a;

        // Reset state.
        cycle(1'b1, 1'b1, 1'b0, P0);
        check("rst.step",  32'(sa), 32'd0);
        check("rst.f",     32'(fa), 32'd0);
        check("rst.g",     32'(ga), 32'd0);
        check("rst.err",   32'(ea), 32'd0);
        check("rst.count", 32'(ca), 32'd0);

        // Basic walk 0->1->2->3->0.
        cycle(1'b0, 1'b1, 1'b1, P0); check("walk.s1", 32'(sa), 32'd1); check("walk.f1", 32'(fa), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, P0); check("walk.s2", 32'(sa), 32'd2); check("walk.f2", 32'(fa), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, P0); check("walk.s3", 32'(sa), 32'd3); check("walk.f3", 32'(fa), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, P0); check("walk.s0", 32'(sa), 32'd0); check("walk.f0", 32'(fa), 32'd0);
        check("walk.g", 32'(ga), 32'd1);
        check("walk.count", 32'(ca), 32'd1);

        // HOLD=3 qualification on dut_b.
        cycle(1'b1, 1'b1, 1'b0, P0);
        cycle(1'b0, 1'b1, 1'b1, P0); check("hold.1", 32'(sb), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, P0); check("hold.2", 32'(sb), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, P0); check("hold.break", 32'(sb), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, P0); check("hold.3", 32'(sb), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, P0); check("hold.4", 32'(sb), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, P0); check("hold.adv", 32'(sb), 32'd1);

        // Timeout in step 2 on dut_a.
        cycle(1'b1, 1'b1, 1'b0, P0);
        run_seq(P0);
        cycle(1'b0, 1'b1, 1'b1, P0);
        cycle(1'b0, 1'b1, 1'b0, P0); check("tmo.s2", 32'(sa), 32'd2);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 1'b0, P0);
            check("tmo.wait.step", 32'(sa), 32'd2);
            check("tmo.wait.err", 32'(ea), 32'd0);
        end
        cycle(1'b0, 1'b1, 1'b0, P0);
        check("tmo.err", 32'(ea), 32'd1);
        check("tmo.step", 32'(sa), 32'd0);
        check("tmo.g", 32'(ga), 32'd0);
        check("tmo.count", 32'(ca), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, P0);
        check("tmo.err.pulse", 32'(ea), 32'd0);

        // Count saturation with CNT_W=2 and sticky G.
        cycle(1'b1, 1'b1, 1'b0, P0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, 1'b1, P0);
            check("sat.g.clear", 32'(ga), 32'd0);
            cycle(1'b0, 1'b1, 1'b0, P0);
            cycle(1'b0, 1'b1, 1'b1, P0);
            cycle(1'b0, 1'b1, 1'b0, P0);
            check("sat.count", 32'(ca), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
            check("sat.g.set", 32'(ga), 32'd1);
            cycle(1'b0, 1'b1, 1'b0, P0);
            check("sat.g.idle", 32'(ga), 32'd1);
        end

        // Reset mid-sequence, then En=0 abort.
        cycle(1'b1, 1'b1, 1'b0, P0);
        run_seq(P0);
        cycle(1'b0, 1'b1, 1'b1, P0);
        cycle(1'b0, 1'b1, 1'b0, P0);
        cycle(1'b0, 1'b1, 1'b1, P0); check("rstmid.pre", 32'(sa), 32'd3);
        cycle(1'b1, 1'b1, 1'b0, P0);
        check("rstmid.step", 32'(sa), 32'd0);
        check("rstmid.f", 32'(fa), 32'd0);
        check("rstmid.g", 32'(ga), 32'd0);
        check("rstmid.count", 32'(ca), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, P0);
        cycle(1'b0, 1'b1, 1'b0, P0); check("en.pre", 32'(sa), 32'd2);
        cycle(1'b0, 1'b0, 1'b1, P0);
        check("en.step", 32'(sa), 32'd0);
        check("en.err", 32'(ea), 32'd0);

        // Pattern change mid-sequence is ignored until return to step 0.
        cycle(1'b1, 1'b1, 1'b0, P0);
        cycle(1'b0, 1'b1, 1'b1, P0); check("pat.s1", 32'(sa), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, P1); check("pat.s2", 32'(sa), 32'd2);
        cycle(1'b0, 1'b1, 1'b1, P1); check("pat.s3", 32'(sa), 32'd3);
        cycle(1'b0, 1'b1, 1'b0, P1); check("pat.s0", 32'(sa), 32'd0);
        check("pat.count", 32'(ca), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, P1); check("pat.new1", 32'(sa), 32'd1);
        cycle(1'b0, 1'b1, 1'b1, P1); check("pat.new2", 32'(sa), 32'd2);

        // Biased random traffic against the model.
        pat = P0;
        cycle(1'b1, 1'b1, 1'b0, pat);
        for (int n = 0; n < 2000; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 31) != 0);
            if ($urandom_range(0, 15) == 0) pat = 4'($urandom);
            eff = (m_step[0] == 0 && m_hold[0] == 0) ? pat : m_pat[0];
            a = ($urandom_range(0, 3) != 0) ? eff[m_step[0]] : 1'($urandom);
            cycle(r, en, a, pat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_match_fsm.md
SEQ_MATCH_FSM -- requirements
Module: seq_match_fsm

Interface
REQ-001 SHALL have parameter LEN, default 4, meaning pattern length in steps, legal range 2..16.
REQ-002 SHALL have parameter HOLD, default 1, meaning consecutive cycles A must equal the expected level before advancing, legal range 1..255.
REQ-003 SHALL have parameter TIMEOUT, default 0, meaning maximum cycles allowed in any step other than step 0; 0 disables the timeout.
REQ-004 SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-005 SHALL have port Clock, input, 1, the single clock; all logic on posedge.
REQ-006 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port En, input, 1: 1 = detector runs; 0 = forced abort to step 0.
REQ-008 SHALL have port A, input, 1, the monitored level, sampled every posedge.
REQ-009 SHALL have port Pattern, input, LEN, where bit k is the expected level of A at step k.
REQ-010 SHALL have port F, output, 1, high while in the final step (LEN-1).
REQ-011 SHALL have port G, output, 1, sticky completion flag.
REQ-012 SHALL have port Err, output, 1, one-cycle pulse on a timeout abort.
REQ-013 SHALL have port Step, output, clog2(LEN), the current step index.
REQ-014 SHALL have port Count, output, CNT_W, the number of completed matches, saturating.

Function
REQ-015 SHALL keep a step index 0..LEN-1, a hold counter and a timeout counter, all registered.
REQ-016 SHALL capture Pattern into an internal register on every cycle in which Step==0 and the hold counter is 0; the captured value SHALL stay unchanged from then until the sequence returns to step 0.
REQ-017 SHALL, in step k, increment the hold counter when A==pat[k] and clear it to 0 when A!=pat[k].
REQ-018 SHALL advance on the edge where A==pat[k] and hold==HOLD-1, setting hold<=0 and tmo<=0; with HOLD=1 this advances on the first matching edge.
REQ-019 SHALL, on advancing from step 0, clear G to 0.
REQ-020 SHALL, on advancing into step LEN-1, set F to 1.
REQ-021 SHALL, on advancing from step LEN-1, set Step<=0, F<=0, G<=1, and increment Count if Count is below 2^CNT_W-1, otherwise hold Count.
REQ-022 SHALL, while Step!=0 and TIMEOUT!=0, increment tmo each cycle; when tmo==TIMEOUT-1 and there is no advance that edge, set Step<=0, F<=0, hold<=0, tmo<=0, Err<=1 for one cycle, and leave G and Count unchanged.
REQ-023 SHALL give an advance priority over a timeout on the same edge.
REQ-024 SHALL, when En==0, set Step<=0, F<=0, hold<=0, tmo<=0 and Err<=0, hold G and Count, and not count the cycle as a timeout.
REQ-025 SHALL apply priority in the order Reset > En==0 > advance > timeout > wait.
REQ-026 SHALL never leave Step at a value of LEN or above; any illegal value SHALL return to 0 on the next edge.
REQ-027 SHALL keep Err at 0 on every cycle other than the abort pulse.

Reset
REQ-028 SHALL, while Reset==1 at a posedge, set Step=0, F=0, G=0, Err=0, Count=0, hold=0, tmo=0 and the pattern register to Pattern.
REQ-029 SHALL let Reset asserted mid-sequence (any Step) take effect at that edge with no completion counted.
REQ-030 SHALL begin evaluation on the first posedge after Reset falls.

Verification
REQ-031 SHALL verify: LEN=4, HOLD=1, Pattern=4'b0101 (step0 expects 1), A=1,0,1,0 on successive edges -> Step 0->1->2->3->0; F=1 only while Step==3; G=1 after the 4th edge; Count=1.
REQ-032 SHALL verify: HOLD=3, A=1 for 2 cycles, then 0, then 1 for 3 cycles -> Step stays 0 until the 3rd consecutive 1, then becomes 1.
REQ-033 SHALL verify: TIMEOUT=5, sequence reaches Step 2 and A holds the wrong level -> Err pulses on the 5th cycle in step 2; Step=0; G and Count unchanged.
REQ-034 SHALL verify: CNT_W=2, 5 complete sequences -> Count sequence 1,2,3,3,3; G stays 1 between matches and clears on the next step-0 advance.
REQ-035 SHALL verify: Reset=1 while Step==3 -> next edge Step=0, F=0, G=0, Count=0; and En=0 while Step==2 -> Step=0, Err=0.
REQ-036 SHALL verify: Pattern changed while Step==1 -> sequence follows the old pattern; the new value is used after the return to step 0.
